dmem_responder: RTL

Data-memory responder at the far end of the processor's dmem port: accepts `address_dmem`/`data`/`wren` each cycle and returns `q_dmem` one rising edge later. Word-addressed RAM plus a small memory-mapped I/O page: free-running cycle counter, LED register, and an 8-deep transmit FIFO drained by an external consumer over a valid/ready port. Sits in the wrapper between the processor and board I/O, replacing the bare dmem instance.

---
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the processor's dmem port.
// Serves a word-addressed RAM and a small memory-mapped I/O page:
// a free-running cycle counter, an LED register and a transmit FIFO
// drained by an external consumer over a valid/ready handshake.
// All reads return on q_dmem one rising edge after the address is presented.

module dmem_responder #(
  parameter int RAM_ADDR_BITS = 12,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [15:0] leds,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_WORDS = 2 ** RAM_ADDR_BITS;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_LEDS   = 4'h1;
  localparam logic [3:0] OFF_TXDATA = 4'h2;
  localparam logic [3:0] OFF_STATUS = 4'h3;

  // RAM storage and its registered read port
  logic [31:0] r_mem [0:RAM_WORDS-1];
  logic [31:0] r_ramQ;

  // Read-path selection registered alongside the RAM read
  logic        r_selRam;
  logic [31:0] r_mmioQ;

  // MMIO state
  logic [31:0] r_cycle;
  logic [15:0] r_leds;
  logic        r_overflow;

  // Transmit FIFO state
  logic [31:0]      r_buf [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;

  // Decode and control wires
  logic                     w_ramSel;
  logic                     w_mmioSel;
  logic [3:0]               w_offset;
  logic [RAM_ADDR_BITS-1:0] w_ramAddr;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_pushAccept;
  logic                     w_ovfSet;
  logic                     w_ovfClr;
  logic                     w_ledWrite;
  logic [4:0]               w_countField;
  logic [31:0]              w_status;
  logic [31:0]              w_mmioRd;
  logic [CNT_W-1:0]         w_countNext;

  assign w_ramSel  = (address_dmem[31:RAM_ADDR_BITS] == '0);
  assign w_mmioSel = (address_dmem[31:4] == 28'hFFFFFFF);
  assign w_offset  = address_dmem[3:0];
  assign w_ramAddr = address_dmem[RAM_ADDR_BITS-1:0];

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // A pop only happens when the head is valid, so an empty FIFO never pops
  assign w_push       = w_mmioSel & wren & (w_offset == OFF_TXDATA);
  assign w_pop        = tx_valid & tx_ready;
  assign w_pushAccept = w_push & (~w_full | w_pop);
  assign w_ovfSet     = w_push & w_full & ~w_pop;
  assign w_ovfClr     = w_mmioSel & wren & (w_offset == OFF_STATUS) & data[2];
  assign w_ledWrite   = w_mmioSel & wren & (w_offset == OFF_LEDS);

  assign w_countField = 5'(r_count);
  assign w_status     = {23'd0, w_countField, 1'b0, r_overflow, w_full, w_empty};

  assign tx_valid = ~w_empty;
  assign tx_data  = w_empty ? 32'd0 : r_buf[r_rdPtr];
  assign leds     = r_leds;
  assign q_dmem   = r_selRam ? r_ramQ : r_mmioQ;

  // RAM: read-before-write, so a write cycle returns the word's old contents
  always_ff @(posedge clock) begin
    if (w_ramSel && wren) begin
      r_mem[w_ramAddr] <= data;
    end
    r_ramQ <= r_mem[w_ramAddr];
  end

  // MMIO read mux; sees state before the current edge, unmapped reads give 0
  always_comb begin
    w_mmioRd = 32'd0;
    if (w_mmioSel) begin
      case (w_offset)
        OFF_CYCLE:  w_mmioRd = r_cycle;
        OFF_LEDS:   w_mmioRd = {16'd0, r_leds};
        OFF_STATUS: w_mmioRd = w_status;
        default:    w_mmioRd = 32'd0;
      endcase
    end
  end

  // Capture which source feeds q_dmem and the MMIO read value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_selRam <= 1'b0;
      r_mmioQ  <= 32'd0;
    end else begin
      r_selRam <= w_ramSel;
      r_mmioQ  <= w_mmioRd;
    end
  end

  // Free-running cycle counter, wraps naturally at 32 bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // LED register written from the low half of the data bus
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_leds <= 16'd0;
    end else if (w_ledWrite) begin
      r_leds <= data[15:0];
    end
  end

  // Sticky overflow flag; a new overflow beats a clear on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovfSet) begin
      r_overflow <= 1'b1;
    end else if (w_ovfClr) begin
      r_overflow <= 1'b0;
    end
  end

  // FIFO storage; contents are masked on tx_data while empty so no reset needed
  always_ff @(posedge clock) begin
    if (w_pushAccept) begin
      r_buf[r_wrPtr] <= data;
    end
  end

  // Next occupancy from accepted pushes and pops
  always_comb begin
    w_countNext = r_count;
    if (w_pushAccept && !w_pop) begin
      w_countNext = r_count + CNT_W'(1);
    end else if (!w_pushAccept && w_pop) begin
      w_countNext = r_count - CNT_W'(1);
    end
  end

  // FIFO pointers and count; pointers wrap modulo the power-of-two depth
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushAccept) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= w_countNext;
    end
  end

endmodule
